// File: rtl/psu_pkg.sv
// Shared types and defaults for the ADC serial reader: FSM state encoding and frame geometry.
package psu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FRAME = 2'd1,
      DONE  = 2'd2,
      QUIET = 2'd3
   } adc_state_t;

   localparam int DEF_FRAME_BITS = 16;
   localparam int DEF_LEAD_ZEROS = 3;

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// Serial clock divider for the ADC frame: sclk low then high for CLK_DIV cycles per bit,
// with a strobe on the cycle that ends in a 0->1 sclk edge and one on the frame's last cycle.
module adc_sclk_gen
   import psu_pkg::*;
#(
   parameter int CLK_DIV    = 2,
   parameter int FRAME_BITS = DEF_FRAME_BITS,
   localparam int BW        = cnt_width(FRAME_BITS + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          run,
   output logic          sclk,
   output logic          rise,
   output logic          frame_end,
   output logic [BW-1:0] bit_idx
);

   localparam int DW = cnt_width(CLK_DIV);
   localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);

   logic [DW-1:0] div_cnt;
   logic          half_end;

   assign half_end  = (div_cnt == '0);
   assign rise      = run & ~sclk & half_end;
   assign frame_end = run & sclk & half_end & (bit_idx == BIT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk    <= 1'b1;
         div_cnt <= '0;
         bit_idx <= '0;
      end else if (start) begin
         sclk    <= 1'b0;
         div_cnt <= DIV_LOAD;
         bit_idx <= '0;
      end else if (run & ~frame_end) begin
         if (half_end) begin
            div_cnt <= DIV_LOAD;
            sclk    <= ~sclk;
            // a bit ends on the high->low transition
            if (sclk) bit_idx <= bit_idx + 1'b1;
         end else begin
            div_cnt <= div_cnt - 1'b1;
         end
      end else begin
         sclk    <= 1'b1;
         div_cnt <= '0;
         bit_idx <= '0;
      end
   end

endmodule

// File: rtl/adc_spi_reader.sv
// SPI master for an ADC081S-style serial ADC, producing held samples plus a valid strobe.
// Define ADC_AVG_EN to output a running average of the last 4 good conversions.
//
//  state | meaning
//  IDLE  | cs_n high, waiting for en
//  FRAME | cs_n low, FRAME_BITS sclk periods clocked out, sdo shifted in
//  DONE  | one cycle: publish sample or flag frame_err
//  QUIET | cs_n held high for QUIET_CYC cycles before the next frame
module adc_spi_reader
   import psu_pkg::*;
#(
   parameter int ADC_WIDTH  = 8,
   parameter int CLK_DIV    = 2,
   parameter int FRAME_BITS = DEF_FRAME_BITS,
   parameter int LEAD_ZEROS = DEF_LEAD_ZEROS,
   parameter int QUIET_CYC  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 adc_sdo,
   output logic                 adc_cs_n,
   output logic                 adc_sclk,
   output logic [ADC_WIDTH-1:0] sample,
   output logic                 sample_valid,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int BW = cnt_width(FRAME_BITS + 1);
   localparam int QW = cnt_width(QUIET_CYC);
   localparam logic [QW-1:0] QUIET_LOAD = QW'(QUIET_CYC - 1);
   localparam logic [BW-1:0] LEAD_END   = BW'(LEAD_ZEROS);
   localparam logic [BW-1:0] DATA_END   = BW'(LEAD_ZEROS + ADC_WIDTH);

   adc_state_t           state, state_nxt;
   logic [QW-1:0]        quiet_cnt;
   logic [ADC_WIDTH-1:0] shift;
   logic [ADC_WIDTH-1:0] sample_nxt;
   logic                 lead_err;
   logic                 start, run, rise, frame_end;
   logic [BW-1:0]        bit_idx;

   assign run   = (state == FRAME);
   assign start = (state_nxt == FRAME) && (state != FRAME);

   adc_sclk_gen #(
      .CLK_DIV    (CLK_DIV),
      .FRAME_BITS (FRAME_BITS)
   ) u_sclk_gen (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .run       (run),
      .sclk      (adc_sclk),
      .rise      (rise),
      .frame_end (frame_end),
      .bit_idx   (bit_idx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (en) state_nxt = FRAME;
         FRAME:   if (frame_end) state_nxt = DONE;
         DONE:    state_nxt = QUIET;
         QUIET:   if (quiet_cnt == '0) state_nxt = en ? FRAME : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

`ifdef ADC_AVG_EN
   localparam int SW = ADC_WIDTH + 2;
   logic [ADC_WIDTH-1:0] hist0, hist1, hist2;
   logic [SW-1:0]        avg_sum;

   assign avg_sum    = SW'(shift) + SW'(hist0) + SW'(hist1) + SW'(hist2);
   assign sample_nxt = avg_sum[SW-1:2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist0 <= '0;
         hist1 <= '0;
         hist2 <= '0;
      end else if (frame_end && !lead_err) begin
         hist0 <= shift;
         hist1 <= hist0;
         hist2 <= hist1;
      end
   end
`else
   assign sample_nxt = shift;
`endif

   // Outputs are registered from the next state so they line up with state entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         adc_cs_n     <= 1'b1;
         busy         <= 1'b0;
         sample_valid <= 1'b0;
         frame_err    <= 1'b0;
         sample       <= '0;
         shift        <= '0;
         lead_err     <= 1'b0;
         quiet_cnt    <= '0;
      end else begin
         adc_cs_n     <= (state_nxt != FRAME);
         busy         <= (state_nxt == FRAME) || (state_nxt == DONE);
         sample_valid <= 1'b0;
         frame_err    <= 1'b0;

         if (start) begin
            shift    <= '0;
            lead_err <= 1'b0;
         end else if (rise) begin
            if (bit_idx < LEAD_END)      lead_err <= lead_err | adc_sdo;
            else if (bit_idx < DATA_END) shift    <= ADC_WIDTH'({shift, adc_sdo});
         end

         if (frame_end) begin
            if (lead_err) begin
               frame_err <= 1'b1;
            end else begin
               sample_valid <= 1'b1;
               sample       <= sample_nxt;
            end
         end

         if (state == DONE)                          quiet_cnt <= QUIET_LOAD;
         else if (state == QUIET && quiet_cnt != '0) quiet_cnt <= quiet_cnt - 1'b1;
      end
   end

endmodule

// File: tb/tb_adc_spi_reader.sv
// Bench for adc_spi_reader: serial ADC model on the pins, timeline reference model, directed + random phases.
module tb_adc_spi_reader;

   localparam int W         = 8;
   localparam int CLK_DIV   = 2;
   localparam int FB        = 16;
   localparam int LZ        = 3;
   localparam int QC        = 4;
   localparam int TR        = FB - LZ - W;
   localparam int FRAME_CYC = FB * 2 * CLK_DIV;
   localparam int PERIOD    = FRAME_CYC + 1 + QC;

   typedef logic [LZ+W-1:0] word_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en = 1'b0;
   logic         adc_sdo = 1'b0;
   logic         adc_cs_n, adc_sclk, sample_valid, frame_err, busy;
   logic [W-1:0] sample;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   word_t adc_q[$];
   word_t exp_q[$];

   adc_spi_reader #(
      .ADC_WIDTH (W),
      .CLK_DIV   (CLK_DIV),
      .FRAME_BITS(FB),
      .LEAD_ZEROS(LZ),
      .QUIET_CYC (QC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .adc_sdo     (adc_sdo),
      .adc_cs_n    (adc_cs_n),
      .adc_sclk    (adc_sclk),
      .sample      (sample),
      .sample_valid(sample_valid),
      .frame_err   (frame_err),
      .busy        (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      $display("FAIL %s: got timeout, expected event within bound (cycle %0d)", name, cyc);
   endtask

   function automatic word_t mk(input logic [LZ-1:0] lead, input logic [W-1:0] d);
      return {lead, d};
   endfunction

   // ADC: drives bit 0 when cs_n falls, then the next bit on every sclk fall.
   initial begin
      logic          prev_cs, prev_sclk;
      logic [FB-1:0] fbits;
      word_t         w;
      int            k;
      prev_cs = 1'b1; prev_sclk = 1'b1; fbits = '0; k = 0;
      forever begin
         @(negedge clk);
         if (!rst && prev_cs && !adc_cs_n) begin
            if (adc_q.size() > 0) w = adc_q.pop_front();
            else w = mk(($urandom_range(0, 3) == 0) ? LZ'($urandom_range(1, 7)) : '0, W'($urandom));
            exp_q.push_back(w);
            fbits = {w, TR'($urandom)};
            k = 0;
            adc_sdo = fbits[FB-1];
         end else if (!rst && !adc_cs_n && prev_sclk && !adc_sclk) begin
            if (k < FB - 1) k++;
            adc_sdo = fbits[FB-1-k];
         end else if (adc_cs_n) begin
            adc_sdo = 1'($urandom_range(0, 1));
         end
         prev_cs = adc_cs_n;
         prev_sclk = adc_sclk;
      end
   end

   // Reference timeline: t counts cycles since cs_n fell; frame, then 1 DONE cycle, then QC quiet cycles.
   initial begin
      bit           m_act;
      int           t;
      logic [W-1:0] m_sample;
      logic         e_valid, e_err, in_frame;
      word_t        w;
`ifdef ADC_AVG_EN
      int           h0, h1, h2;
      h0 = 0; h1 = 0; h2 = 0;
`endif
      m_act = 1'b0; t = 0; m_sample = '0;
      forever begin
         @(posedge clk);
         #1;
         e_valid = 1'b0;
         e_err   = 1'b0;
         if (rst) begin
            m_act = 1'b0; t = 0; m_sample = '0;
            exp_q.delete();
`ifdef ADC_AVG_EN
            h0 = 0; h1 = 0; h2 = 0;
`endif
         end else if (!m_act) begin
            if (en) begin m_act = 1'b1; t = 0; end
         end else begin
            t++;
            if (t == PERIOD) begin
               if (en) t = 0;
               else m_act = 1'b0;
            end
         end
         if (!rst && m_act && t == FRAME_CYC) begin
            if (exp_q.size() == 0) begin
               fail_now("model_frame_word");
            end else begin
               w = exp_q.pop_front();
               if (w[LZ+W-1:W] != '0) begin
                  e_err = 1'b1;
               end else begin
                  e_valid = 1'b1;
`ifdef ADC_AVG_EN
                  m_sample = W'((int'(w[W-1:0]) + h0 + h1 + h2) / 4);
                  h2 = h1; h1 = h0; h0 = int'(w[W-1:0]);
`else
                  m_sample = w[W-1:0];
`endif
               end
            end
         end
         in_frame = m_act && (t < FRAME_CYC);
         check("cs_n", adc_cs_n, !in_frame);
         check("sclk", adc_sclk, in_frame ? ((t / CLK_DIV) % 2) : 1);
         check("busy", busy, m_act && (t <= FRAME_CYC));
         check("sample_valid", sample_valid, e_valid);
         check("frame_err", frame_err, e_err);
         check("sample", sample, m_sample);
      end
   end

   task automatic wait_cs_fall(output int tf, output int high);
      logic pc;
      pc = adc_cs_n; tf = -1; high = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (pc && !adc_cs_n) begin tf = cyc; break; end
         if (adc_cs_n) high++;
         pc = adc_cs_n;
      end
      if (tf < 0) fail_now("wait_cs_fall");
   endtask

   task automatic wait_event(input bit want_err, output int tv, output int rises, output int n_valid);
      logic ps;
      ps = adc_sclk; tv = -1; rises = 0; n_valid = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!ps && adc_sclk) rises++;
         ps = adc_sclk;
         if (want_err ? frame_err : sample_valid) begin tv = cyc; break; end
         if (sample_valid) n_valid++;
      end
      if (tv < 0) fail_now(want_err ? "wait_frame_err" : "wait_sample_valid");
   endtask

   initial begin
      int           tf, high, tv, tv_prev, rises, nv, toggles, lowc, r;
      logic         ps;
      logic [W-1:0] seq3 [3];
      seq3[0] = 8'h00; seq3[1] = 8'hFF; seq3[2] = 8'h80;

      // reset held with en high
      rst = 1'b1; en = 1'b1; toggles = 0;
      @(negedge clk);
      ps = adc_sclk;
      repeat (10) begin
         @(negedge clk);
         if (adc_sclk !== ps) toggles++;
         ps = adc_sclk;
      end
      check("reset_sclk_toggles", toggles, 0);
      check("reset_cs_n", adc_cs_n, 1);
      check("reset_sclk", adc_sclk, 1);
      check("reset_sample", sample, 8'h00);
      check("reset_valid", sample_valid, 0);
      check("reset_busy", busy, 0);

      // first frame: latency and sclk pulse count
      adc_q.push_back(mk(3'b000, 8'hA5));
      @(negedge clk);
      rst = 1'b0;
      wait_cs_fall(tf, high);
      wait_event(1'b0, tv, rises, nv);
      check("first_latency", tv - tf, 64);
      check("first_sclk_pulses", rises, 16);
`ifndef ADC_AVG_EN
      check("first_sample", sample, 8'hA5);
`endif
      tv_prev = tv;

      // back-to-back frames
      for (int i = 0; i < 3; i++) adc_q.push_back(mk(3'b000, seq3[i]));
      for (int i = 0; i < 3; i++) begin
         wait_cs_fall(tf, high);
         check("cs_high_gap", high + 1, 5);
         wait_event(1'b0, tv, rises, nv);
         check("valid_spacing", tv - tv_prev, 69);
`ifndef ADC_AVG_EN
         check("b2b_sample", sample, seq3[i]);
`endif
         tv_prev = tv;
      end

      // good frame followed by one with a nonzero leading bit
      adc_q.push_back(mk(3'b000, 8'h5A));
      adc_q.push_back(mk(3'b100, 8'h33));
      wait_event(1'b0, tv, rises, nv);
      tv_prev = tv;
      wait_event(1'b1, tv, rises, nv);
      check("err_spacing", tv - tv_prev, 69);
      check("err_no_valid", nv, 0);
`ifndef ADC_AVG_EN
      check("err_sample_held", sample, 8'h5A);
      @(negedge clk);
      check("err_sample_held_after", sample, 8'h5A);
`endif

      // en dropped at the fifth sclk pulse
      adc_q.push_back(mk(3'b000, 8'h3C));
      wait_cs_fall(tf, high);
      r = 0; ps = adc_sclk;
      for (int i = 0; i < 100 && r < 5; i++) begin
         @(negedge clk);
         if (!ps && adc_sclk) r++;
         ps = adc_sclk;
      end
      en = 1'b0;
      wait_event(1'b0, tv, rises, nv);
      check("en_drop_latency", tv - tf, 64);
`ifndef ADC_AVG_EN
      check("en_drop_sample", sample, 8'h3C);
`endif
      lowc = 0;
      repeat (100) begin
         @(negedge clk);
         if (!adc_cs_n) lowc++;
      end
      check("en_drop_idle_cs_low_cycles", lowc, 0);
      check("en_drop_idle_busy", busy, 0);

      // reset in the middle of a frame
      en = 1'b1;
      wait_cs_fall(tf, high);
      repeat (20) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_cs_n", adc_cs_n, 1);
      check("midrst_sclk", adc_sclk, 1);
      check("midrst_sample", sample, 8'h00);
      check("midrst_busy", busy, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // random en toggling and occasional reset pulses
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (rst) rst = 1'b0;
         else if ($urandom_range(0, 1499) == 0) rst = 1'b1;
         if ($urandom_range(0, 199) == 0) en = ~en;
      end

`ifdef ADC_AVG_EN
      begin
         logic [W-1:0] avg_exp [4];
         avg_exp[0] = 8'h04; avg_exp[1] = 8'h0C; avg_exp[2] = 8'h18; avg_exp[3] = 8'h28;
         @(negedge clk);
         rst = 1'b1; en = 1'b1;
         adc_q.delete();
         adc_q.push_back(mk(3'b000, 8'h10));
         adc_q.push_back(mk(3'b000, 8'h20));
         adc_q.push_back(mk(3'b000, 8'h30));
         adc_q.push_back(mk(3'b000, 8'h40));
         @(negedge clk);
         rst = 1'b0;
         for (int i = 0; i < 4; i++) begin
            wait_event(1'b0, tv, rises, nv);
            check("avg_sample", sample, avg_exp[i]);
         end
      end
`endif

      en = 1'b0;
      repeat (80) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
